multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALUOP_W, default 3: width of alu_op; values >3 zero-extend the codes of REQ-014.
REQ-002 Parameter MEM_WAIT_MAX, default 15: memory wait-cycle limit before mem_timeout.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 opcode  input  6  instruction[31:26] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory access complete this cycle.
REQ-008 state  output  4  current FSM state code.
REQ-009 Control outputs, 1 bit unless stated: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a, reg_dst[2], alu_src_b[2], pc_source[2], alu_op[ALUOP_W].
REQ-010 Status outputs: instr_done (1-cycle pulse), illegal_op (1-cycle pulse), mem_timeout (1-cycle pulse).

Function
REQ-011 States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JUMP=10, JAL=11; codes 12-15 unused, go to FETCH next cycle with all controls low.
REQ-012 Opcode latched into op_q on DECODE entry edge (end of FETCH); later states decode op_q only.
REQ-013 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000; hold until mem_ready=1, then ir_write=1, pc_write=1, pc_source=00 in that cycle, next DECODE.
REQ-014 alu_op codes: 000 add, 001 sub, 010 funct-decode, 100 and, 101 or, 110 slt; all other states drive 000.
REQ-015 DECODE: alu_src_b=11, alu_op=000 (branch target); next by op_q: 000000->EXEC_R; 100011/101011->MEM_ADDR; 000100/000101->BRANCH; 001000/001001/001100/001101/001010/001011->EXEC_I; 000010->JUMP; 000011->JAL when macro present; else illegal_op=1, next FETCH.
REQ-016 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; next MEM_RD (LW) or MEM_WR (SW).
REQ-017 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB.
REQ-018 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=00; instr_done=1; next FETCH.
REQ-019 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready; in that cycle instr_done=1; next FETCH.
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010; EXEC_I: alu_src_a=1, alu_src_b=10, alu_op 000 (ADDI/ADDIU), 100 (ANDI), 101 (ORI), 110 (SLTI/SLTIU); both next ALU_WB.
REQ-021 ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=01 after R-type, 00 after I-type; instr_done=1; next FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, pc_write_cond=zero for BEQ, ~zero for BNE (combinational on zero); instr_done=1; next FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10; instr_done=1; next FETCH.
REQ-024 Wait counter (4+ bits) counts consecutive cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0; cleared on state change; on reaching MEM_WAIT_MAX: mem_timeout=1, all memory controls drop, next FETCH (no PC update).
REQ-025 mem_ready=1 in the same cycle the counter reaches MEM_WAIT_MAX: completion wins, no timeout.
REQ-026 Outputs are Moore (state/op_q decoded) except pc_write_cond, ir_write/pc_write in FETCH, and instr_done in MEM_WR, which also use zero/mem_ready.

Reset
REQ-027 rst_n=0 asynchronously forces state=FETCH, op_q=0, wait counter=0; while asserted all control and status outputs are 0.
REQ-028 Reset mid-access abandons the access; first cycle after release is a fresh FETCH.

Configuration
REQ-029 Macro MCU_JAL_EN: when defined, opcode 000011 goes to JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10 ($31), mem_to_reg=0, alu path carries PC+4; instr_done=1; next FETCH.
REQ-030 Without MCU_JAL_EN, state JAL is unreachable, opcode 000011 raises illegal_op, reg_dst=10 never driven.

Verification
REQ-031 Reset release, mem_ready=1, opcode=000000 -> states 0,1,6,8,0; reg_write=1, reg_dst=01 in state 8; instr_done once.
REQ-032 LW (100011), mem_ready low 3 cycles in MEM_RD -> 3 stall cycles in state 3, then 4; total 8 cycles; mem_to_reg=1 at writeback.
REQ-033 BNE (000101) with zero=0 -> pc_write_cond=1 in state 9; with zero=1 -> 0; BEQ inverse.
REQ-034 mem_ready held 0 in FETCH -> mem_timeout pulse after 15 cycles, state 0, pc_write never asserted.
REQ-035 Opcode 111111 -> illegal_op pulse in DECODE, back to FETCH; opcode 000011 -> JAL with macro, illegal_op without.
REQ-036 rst_n pulsed low during MEM_WR -> mem_write drops immediately, state 0, no instr_done.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Bus between the multicycle control unit and its datapath / memory side.
//
// Signals:
//   opcode, zero, mem_ready  - instruction opcode, ALU zero flag and memory
//                              completion, driven towards the control unit
//   state                    - current FSM state code
//   pc_write .. alu_op       - datapath control strobes and selects
//   instr_done, illegal_op,
//   mem_timeout              - one-cycle status pulses
//
// Modports: slave = control unit side, master = datapath / environment side.
interface multicycle_control_unit_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic [3:0]         state;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         reg_dst;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_source;
  logic [ALUOP_W-1:0] alu_op;
  logic               instr_done;
  logic               illegal_op;
  logic               mem_timeout;

  modport slave (
    input  opcode, zero, mem_ready,
    output state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, reg_dst, alu_src_b,
           pc_source, alu_op, instr_done, illegal_op, mem_timeout
  );

  modport master (
    output opcode, zero, mem_ready,
    input  state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_write, alu_src_a, reg_dst, alu_src_b,
           pc_source, alu_op, instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-style control unit: a 12-state FSM sequencing fetch,
// decode, memory, ALU, branch and jump phases, with a memory wait counter
// that abandons an access after MEM_WAIT_MAX stalled cycles.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - multicycle_control_unit_if.slave (opcode/zero/mem_ready in,
//            state code, control strobes and status pulses out)
//
// Optional feature: define MCU_JAL_EN to enable the JAL (opcode 000011)
// path. Without it, 000011 is treated as an illegal opcode.
module multicycle_control_unit #(
  parameter int ALUOP_W      = 3,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multicycle_control_unit_if.slave  bus
);

  localparam int CNT_W = ($clog2(MEM_WAIT_MAX + 1) > 4) ? $clog2(MEM_WAIT_MAX + 1) : 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10,
    JAL      = 4'd11
  } state_t;

  state_t           state_q;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] wait_cnt;

  logic in_wait;
  logic at_limit;
  logic timeout;
  logic [2:0] aop;

  // Post-decode destination; FETCH doubles as the "illegal opcode" marker.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:                 return EXEC_R;
      OP_LW, OP_SW:             return MEM_ADDR;
      OP_BEQ, OP_BNE:           return BRANCH;
      OP_ADDI, OP_ADDIU, OP_ANDI,
      OP_ORI, OP_SLTI, OP_SLTIU: return EXEC_I;
      OP_J:                     return JUMP;
`ifdef MCU_JAL_EN
      OP_JAL:                   return JAL;
`endif
      default:                  return FETCH;
    endcase
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI:          return 3'b100;
      OP_ORI:           return 3'b101;
      OP_SLTI, OP_SLTIU: return 3'b110;
      default:          return 3'b000;
    endcase
  endfunction

  assign in_wait  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign at_limit = (wait_cnt == CNT_W'(MEM_WAIT_MAX));
  // A completing access in the limit cycle wins over the timeout.
  assign timeout  = in_wait && at_limit && !bus.mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
    end else begin
      // Counter only runs while stalled in a memory-wait state; every state
      // change, completion or timeout clears it.
      if (in_wait && !bus.mem_ready && !at_limit)
        wait_cnt <= wait_cnt + CNT_W'(1);
      else
        wait_cnt <= '0;

      case (state_q)
        FETCH: begin
          if (bus.mem_ready) begin
            op_q    <= bus.opcode;
            state_q <= DECODE;
          end
        end
        DECODE:   state_q <= decode_next(op_q);
        MEM_ADDR: state_q <= (op_q == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD: begin
          if (bus.mem_ready)  state_q <= MEM_WB;
          else if (at_limit)  state_q <= FETCH;
        end
        MEM_WR: begin
          if (bus.mem_ready || at_limit) state_q <= FETCH;
        end
        EXEC_R, EXEC_I: state_q <= ALU_WB;
        // Writeback, branch, jump, JAL and unused codes all return to fetch.
        default: state_q <= FETCH;
      endcase
    end
  end

  always_comb begin
    bus.state         = state_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.pc_source     = 2'b00;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.mem_timeout   = 1'b0;
    aop               = 3'b000;

    // Everything is held low while reset is asserted, even though the
    // state register already reads FETCH.
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_b  = 2'b11;
          bus.illegal_op = (decode_next(op_q) == FETCH);
        end
        MEM_ADDR: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        MEM_RD: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        MEM_WB: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 1'b1;
          bus.instr_done = 1'b1;
        end
        MEM_WR: begin
          bus.mem_write  = 1'b1;
          bus.i_or_d     = 1'b1;
          bus.instr_done = bus.mem_ready;
        end
        EXEC_R: begin
          bus.alu_src_a = 1'b1;
          aop           = 3'b010;
        end
        EXEC_I: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
          aop           = imm_alu_op(op_q);
        end
        ALU_WB: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = (op_q == OP_RTYPE) ? 2'b01 : 2'b00;
          bus.instr_done = 1'b1;
        end
        BRANCH: begin
          bus.alu_src_a     = 1'b1;
          aop               = 3'b001;
          bus.pc_source     = 2'b01;
          bus.pc_write_cond = (op_q == OP_BEQ) ? bus.zero : !bus.zero;
          bus.instr_done    = 1'b1;
        end
        JUMP: begin
          bus.pc_write   = 1'b1;
          bus.pc_source  = 2'b10;
          bus.instr_done = 1'b1;
        end
`ifdef MCU_JAL_EN
        JAL: begin
          // ALU computes PC+4 (PC + 4 through src_a=0/src_b=01) for $31.
          bus.pc_write   = 1'b1;
          bus.pc_source  = 2'b10;
          bus.reg_write  = 1'b1;
          bus.reg_dst    = 2'b10;
          bus.alu_src_b  = 2'b01;
          bus.instr_done = 1'b1;
        end
`endif
        default: ;
      endcase

      // Abandoned access: drop every memory strobe and flag the timeout.
      if (timeout) begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.i_or_d      = 1'b0;
        bus.mem_timeout = 1'b1;
      end
    end

    bus.alu_op = ALUOP_W'(aop);
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit. A reference
// model expands each instruction into the cycle-by-cycle list of expected
// states and control words, which is then replayed against the DUT.
module tb_multicycle_control_unit;

  localparam int WMAX = 15;
  localparam logic [20:0] MEM_BITS = 21'h70000;
  localparam logic [20:0] TO_BIT   = 21'h00001;

  typedef struct {
    logic [3:0]  st;
    bit          rdy;
    bit          z;
    logic [5:0]  opc;
    logic [20:0] wd;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  step_t plan[$];

  multicycle_control_unit_if #(.ALUOP_W(3)) bus ();

  multicycle_control_unit #(.ALUOP_W(3), .MEM_WAIT_MAX(WMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [20:0] w(input bit pcw, pwc, iord, mr, mw, irw, m2r, rw, asa,
                                    input bit [1:0] rd, asb, pcs, input bit [2:0] aop,
                                    input bit done, ill, to);
    return {pcw, pwc, iord, mr, mw, irw, m2r, rw, asa, rd, asb, pcs, aop, done, ill, to};
  endfunction

  function automatic logic [20:0] obs();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.reg_dst,
            bus.alu_src_b, bus.pc_source, bus.alu_op[2:0], bus.instr_done,
            bus.illegal_op, bus.mem_timeout};
  endfunction

  function automatic bit legal(input logic [5:0] op);
`ifdef MCU_JAL_EN
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C,
                      6'h0D, 6'h0A, 6'h0B, 6'h02, 6'h03};
`else
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C,
                      6'h0D, 6'h0A, 6'h0B, 6'h02};
`endif
  endfunction

  function automatic bit [2:0] ialu(input logic [5:0] op);
    if (op == 6'h0C) return 3'b100;
    if (op == 6'h0D) return 3'b101;
    if (op == 6'h0A || op == 6'h0B) return 3'b110;
    return 3'b000;
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  task automatic push(input logic [3:0] st, input bit rdy, input bit z,
                      input logic [5:0] opc, input logic [20:0] wd);
    step_t s;
    s.st = st; s.rdy = rdy; s.z = z; s.opc = opc; s.wd = wd;
    plan.push_back(s);
  endtask

  // n stalled cycles then completion; n beyond the limit ends in a timeout.
  task automatic wait_phase(input logic [3:0] st, input logic [5:0] opc,
                            input logic [20:0] stall_wd, input logic [20:0] ready_wd,
                            input int n, output bit to);
    if (n > WMAX) begin
      for (int i = 0; i < WMAX; i++) push(st, 1'b0, rb(), opc, stall_wd);
      push(st, 1'b0, rb(), opc, (stall_wd & ~MEM_BITS) | TO_BIT);
      to = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) push(st, 1'b0, rb(), opc, stall_wd);
      push(st, 1'b1, rb(), opc, ready_wd);
      to = 1'b0;
    end
  endtask

  task automatic gen_instr(input logic [5:0] op, input int fstall, input int mstall, input bit z);
    bit to;
    logic [20:0] fs;
    fs = w(0,0,0,1,0,0,0,0,0, 2'd0,2'd1,2'd0, 3'd0, 0,0,0);
    wait_phase(4'd0, op, fs, fs | w(1,0,0,0,0,1,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 0,0,0), fstall, to);
    if (to) return;
    push(4'd1, rb(), rb(), rop(), w(0,0,0,0,0,0,0,0,0, 2'd0,2'd3,2'd0, 3'd0, 0,!legal(op),0));
    if (!legal(op)) return;
    case (op)
      6'h23: begin
        push(4'd2, rb(), rb(), rop(), w(0,0,0,0,0,0,0,0,1, 2'd0,2'd2,2'd0, 3'd0, 0,0,0));
        wait_phase(4'd3, rop(), w(0,0,1,1,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 0,0,0),
                   w(0,0,1,1,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 0,0,0), mstall, to);
        if (!to) push(4'd4, rb(), rb(), rop(), w(0,0,0,0,0,0,1,1,0, 2'd0,2'd0,2'd0, 3'd0, 1,0,0));
      end
      6'h2B: begin
        push(4'd2, rb(), rb(), rop(), w(0,0,0,0,0,0,0,0,1, 2'd0,2'd2,2'd0, 3'd0, 0,0,0));
        wait_phase(4'd5, rop(), w(0,0,1,0,1,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 0,0,0),
                   w(0,0,1,0,1,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0, 1,0,0), mstall, to);
      end
      6'h00: begin
        push(4'd6, rb(), rb(), rop(), w(0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd2, 0,0,0));
        push(4'd8, rb(), rb(), rop(), w(0,0,0,0,0,0,0,1,0, 2'd1,2'd0,2'd0, 3'd0, 1,0,0));
      end
      6'h04, 6'h05: begin
        push(4'd9, rb(), z, rop(),
             w(0, (op == 6'h04) ? z : !z, 0,0,0,0,0,0,1, 2'd0,2'd0,2'd1, 3'd1, 1,0,0));
      end
      6'h02: push(4'd10, rb(), rb(), rop(), w(1,0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd2, 3'd0, 1,0,0));
      6'h03: push(4'd11, rb(), rb(), rop(), w(1,0,0,0,0,0,0,1,0, 2'd2,2'd1,2'd2, 3'd0, 1,0,0));
      default: begin
        push(4'd7, rb(), rb(), rop(), w(0,0,0,0,0,0,0,0,1, 2'd0,2'd2,2'd0, ialu(op), 0,0,0));
        push(4'd8, rb(), rb(), rop(), w(0,0,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0, 3'd0, 1,0,0));
      end
    endcase
  endtask

  // Replays planned cycles: drive at the falling edge, check 1 ns later.
  task automatic run_plan(input int limit);
    step_t s;
    int n;
    n = 0;
    while (plan.size() > 0 && n < limit) begin
      s = plan.pop_front();
      bus.mem_ready = s.rdy;
      bus.zero      = s.z;
      bus.opcode    = s.opc;
      #1;
      chk($sformatf("state@%0d", cyc), 32'(bus.state), 32'(s.st));
      chk($sformatf("ctl@%0d", cyc), 32'(obs()), 32'(s.wd));
      @(negedge clk);
      n++;
      cyc++;
    end
  endtask

  task automatic random_instrs(input int count);
    logic [5:0] ops [13];
    logic [5:0] op;
    int k;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D,
            6'h0A, 6'h0B, 6'h02, 6'h03};
    for (int i = 0; i < count; i++) begin
      k  = $urandom_range(0, 13);
      op = (k == 13) ? rop() : ops[k];
      gen_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), rb());
    end
    run_plan(100000);
  endtask

  initial begin
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    bus.opcode    = 6'h00;
    rst_n         = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_ctl", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    gen_instr(6'h00, 0, 0, 1'b0);   // R-type: 0,1,6,8
    gen_instr(6'h23, 0, 3, 1'b0);   // LW with 3 stalls in MEM_RD
    gen_instr(6'h05, 0, 0, 1'b0);   // BNE, zero=0
    gen_instr(6'h05, 0, 0, 1'b1);   // BNE, zero=1
    gen_instr(6'h04, 0, 0, 1'b0);   // BEQ, zero=0
    gen_instr(6'h04, 0, 0, 1'b1);   // BEQ, zero=1
    gen_instr(6'h00, 16, 0, 1'b0);  // fetch timeout
    gen_instr(6'h00, 15, 0, 1'b0);  // ready in the limit cycle completes
    gen_instr(6'h23, 1, 16, 1'b0);  // MEM_RD timeout
    gen_instr(6'h2B, 0, 16, 1'b0);  // MEM_WR timeout
    gen_instr(6'h2B, 2, 15, 1'b0);  // MEM_WR completes in the limit cycle
    gen_instr(6'h3F, 0, 0, 1'b0);   // illegal opcode
    gen_instr(6'h03, 0, 0, 1'b0);   // JAL or illegal depending on build
    gen_instr(6'h0D, 0, 0, 1'b0);   // ORI
    run_plan(100000);

    random_instrs(80);

    // Reset asserted while MEM_WR is stalled.
    plan.delete();
    gen_instr(6'h2B, 0, 5, 1'b0);
    run_plan(5);
    bus.mem_ready = 1'b0;
    #1;
    chk("mw_before_rst", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mw_rst_state", 32'(bus.state), 32'd0);
    chk("mw_rst_ctl", 32'(obs()), 32'd0);
    plan.delete();
    @(negedge clk);
    rst_n = 1'b1;

    random_instrs(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
